// File: rtl/voice_scheduler.sv
// Four-voice note scheduler: round-robin voice allocation with stealing, per-voice
// reset/prep/go sequencing, and a handshaked saturating mixer for the active voices.
`timescale 1ns/1ps
module voice_scheduler #(
  parameter logic [15:0] LIFE_SAMPLES = 16'd48000,
  parameter logic [11:0] PREP_TIMEOUT = 12'd4095
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        note_valid,
  output logic        note_ready,
  input  logic [9:0]  note_delay,
  input  logic [7:0]  note_velocity,
  output logic [3:0]  v_reset,
  output logic [3:0]  v_go,
  input  logic [3:0]  v_prepped,
  output logic [39:0] v_delay,
  output logic [31:0] v_velocity,
  input  logic [3:0]  v_ready,
  output logic [3:0]  v_received,
  input  logic [71:0] v_data,
  output logic [17:0] sample_out,
  output logic        sample_valid,
  input  logic        sample_full,
  output logic [3:0]  prep_err
);

  localparam logic [2:0] V_IDLE   = 3'd0;
  localparam logic [2:0] V_RST    = 3'd1;
  localparam logic [2:0] V_PREP   = 3'd2;
  localparam logic [2:0] V_GO     = 3'd3;
  localparam logic [2:0] V_ACTIVE = 3'd4;

  localparam logic [1:0] M_WAIT = 2'd0;
  localparam logic [1:0] M_ACK  = 2'd1;
  localparam logic [1:0] M_REL  = 2'd2;

  localparam logic signed [19:0] SAT_MAX = 20'sd131071;
  localparam logic signed [19:0] SAT_MIN = -20'sd131072;

  logic [3:0][2:0]  vs_q, vs_d;
  logic [3:0][15:0] life_q, life_d;
  logic [3:0][11:0] tmo_q, tmo_d;
  logic [3:0]       perr_q, perr_d;
  logic [39:0]      delay_q, delay_d;
  logic [31:0]      vel_q, vel_d;
  logic [1:0]       rr_q, rr_d;
  logic [1:0]       m_q, m_d;
  logic [3:0]       s_q, s_d;
  logic [3:0]       recv_q, recv_d;
  logic [17:0]      sum_q, sum_d;
  logic             sval_q, sval_d;

  logic [3:0]        idle, active, sel;
  logic [1:0]        target, idx;
  logic              found, accept;
  logic signed [19:0] total;
  logic [17:0]       sat;

  always_comb begin
    for (int unsigned i = 0; i < 4; i++) begin
      idle[i]   = (vs_q[i] == V_IDLE);
      active[i] = (vs_q[i] == V_ACTIVE);
    end
  end

  assign note_ready = (m_q == M_WAIT) && !reset;
  assign accept     = note_valid && note_ready;

  // First IDLE voice at or after rr wins; with none idle, voice rr is stolen.
  always_comb begin
    target = rr_q;
    found  = 1'b0;
    idx    = rr_q;
    for (int unsigned k = 0; k < 4; k++) begin
      idx = rr_q + 2'(k);
      if (!found && idle[idx]) begin
        target = idx;
        found  = 1'b1;
      end
    end
  end

  assign sel  = accept ? (4'b0001 << target) : 4'b0000;
  assign rr_d = accept ? target + 2'd1 : rr_q;

  always_comb begin
    delay_d = delay_q;
    vel_d   = vel_q;
    for (int unsigned i = 0; i < 4; i++) begin
      if (sel[i]) begin
        delay_d[10*i +: 10] = note_delay;
        vel_d[8*i +: 8]     = note_velocity;
      end
    end
  end

  always_comb begin
    vs_d   = vs_q;
    life_d = life_q;
    tmo_d  = tmo_q;
    perr_d = perr_q;
    for (int unsigned i = 0; i < 4; i++) begin
      case (vs_q[i])
        V_RST: begin
          vs_d[i]  = V_PREP;
          tmo_d[i] = '0;
        end
        V_PREP: begin
          if (v_prepped[i]) begin
            vs_d[i] = V_GO;
          end else if (tmo_q[i] == PREP_TIMEOUT - 12'd1) begin
            vs_d[i]   = V_IDLE;
            perr_d[i] = 1'b1;
          end else begin
            tmo_d[i] = tmo_q[i] + 12'd1;
          end
        end
        V_GO: begin
          vs_d[i]   = V_ACTIVE;
          life_d[i] = '0;
        end
        V_ACTIVE: begin
          // Life advances once per mixed sample this voice contributed to.
          if (m_q == M_ACK && s_q[i]) begin
            if (life_q[i] == LIFE_SAMPLES - 16'd1) vs_d[i] = V_IDLE;
            else life_d[i] = life_q[i] + 16'd1;
          end
        end
        default: vs_d[i] = V_IDLE;
      endcase
      if (sel[i]) vs_d[i] = V_RST;
    end
  end

  always_comb begin
    total = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (s_q[i]) total = total + {{2{v_data[18*i+17]}}, v_data[18*i +: 18]};
    end
    if (total > SAT_MAX)      sat = 18'h1FFFF;
    else if (total < SAT_MIN) sat = 18'h20000;
    else                      sat = total[17:0];
  end

  always_comb begin
    m_d    = m_q;
    s_d    = s_q;
    recv_d = recv_q;
    sum_d  = sum_q;
    sval_d = 1'b0;
    case (m_q)
      M_WAIT: begin
        if (!sample_full && ((active & ~v_ready) == 4'b0000)) begin
          s_d    = active;
          recv_d = active;
          m_d    = M_ACK;
        end
      end
      M_ACK: begin
        sum_d  = sat;
        sval_d = 1'b1;
        m_d    = M_REL;
      end
      M_REL: begin
        if ((v_ready & s_q) == 4'b0000) begin
          recv_d = '0;
          m_d    = M_WAIT;
        end
      end
      default: begin
        recv_d = '0;
        m_d    = M_WAIT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vs_q    <= '0;
      life_q  <= '0;
      tmo_q   <= '0;
      perr_q  <= '0;
      delay_q <= '0;
      vel_q   <= '0;
      rr_q    <= '0;
      m_q     <= M_WAIT;
      s_q     <= '0;
      recv_q  <= '0;
      sum_q   <= '0;
      sval_q  <= 1'b0;
    end else begin
      vs_q    <= vs_d;
      life_q  <= life_d;
      tmo_q   <= tmo_d;
      perr_q  <= perr_d;
      delay_q <= delay_d;
      vel_q   <= vel_d;
      rr_q    <= rr_d;
      m_q     <= m_d;
      s_q     <= s_d;
      recv_q  <= recv_d;
      sum_q   <= sum_d;
      sval_q  <= sval_d;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < 4; i++) begin
      v_reset[i] = (vs_q[i] == V_RST);
      v_go[i]    = (vs_q[i] == V_GO);
    end
  end

  assign v_delay      = delay_q;
  assign v_velocity   = vel_q;
  assign v_received   = recv_q;
  assign sample_out   = sum_q;
  assign sample_valid = sval_q;
  assign prep_err     = perr_q;

endmodule

// File: tb/tb_voice_scheduler.sv
// Directed bench for voice_scheduler: allocation/stealing, prep timeout, mixer
// saturation, back-pressure and mid-handshake reset, with hand-computed expectations.
`timescale 1ns/1ps
module tb_voice_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        note_valid;
  logic        note_ready;
  logic [9:0]  note_delay;
  logic [7:0]  note_velocity;
  logic [3:0]  v_reset, v_go, v_prepped, v_ready, v_received, prep_err;
  logic [39:0] v_delay;
  logic [31:0] v_velocity;
  logic [71:0] v_data;
  logic [17:0] sample_out;
  logic        sample_valid, sample_full;
  logic [3:0]  ready_en, ready_hold;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  // Voice model: ready drops while acknowledged unless held high on purpose.
  assign v_ready = ready_en & (~v_received | ready_hold);

  voice_scheduler #(
    .LIFE_SAMPLES(16'd6),
    .PREP_TIMEOUT(12'd8)
  ) dut (
    .clk(clk), .reset(reset),
    .note_valid(note_valid), .note_ready(note_ready),
    .note_delay(note_delay), .note_velocity(note_velocity),
    .v_reset(v_reset), .v_go(v_go), .v_prepped(v_prepped),
    .v_delay(v_delay), .v_velocity(v_velocity),
    .v_ready(v_ready), .v_received(v_received), .v_data(v_data),
    .sample_out(sample_out), .sample_valid(sample_valid),
    .sample_full(sample_full), .prep_err(prep_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic send_note(input logic [9:0] d, input logic [7:0] v);
    logic acc;
    acc = 1'b0;
    note_delay    = d;
    note_velocity = v;
    note_valid    = 1'b1;
    for (int n = 0; n < 10; n++) begin
      acc = note_ready;
      tick();
      if (acc) break;
    end
    note_valid = 1'b0;
    check("note_accepted", {39'd0, acc}, 40'd1);
  endtask

  task automatic wait_sample();
    for (int n = 0; n < 20; n++) begin
      tick();
      if (sample_valid) break;
    end
    check("sample_seen", {39'd0, sample_valid}, 40'd1);
  endtask

  logic [3:0]  steal_exp [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
  logic [17:0] d0 [7]  = '{18'h1FFFF, 18'h20000, 18'h00005, 18'h3FFF0, 18'h10000, 18'h3FFFF, 18'h00123};
  logic [17:0] d1 [7]  = '{18'h1FFFF, 18'h20000, 18'h3FFFD, 18'h3FFF0, 18'h10000, 18'h20000, 18'h00456};
  logic [17:0] sx [7]  = '{18'h1FFFF, 18'h20000, 18'h00002, 18'h3FFE0, 18'h1FFFF, 18'h20000, 18'h00000};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int bad;
    int go0;
    reset = 1'b1; note_valid = 1'b0; note_delay = '0; note_velocity = '0;
    v_prepped = '0; v_data = '0; sample_full = 1'b1; ready_en = '0; ready_hold = '0;

    // Reset state
    tick(); tick();
    check("rst_note_ready", {39'd0, note_ready}, 40'd0);
    check("rst_v_received", {36'd0, v_received}, 40'd0);
    check("rst_sample_valid", {39'd0, sample_valid}, 40'd0);
    check("rst_prep_err", {36'd0, prep_err}, 40'd0);
    check("rst_v_reset_go", {32'd0, v_reset, v_go}, 40'd0);
    check("rst_sample_out", {22'd0, sample_out}, 40'd0);
    check("rst_v_delay", v_delay, 40'd0);
    reset = 1'b0;
    tick();
    check("ready_after_reset", {39'd0, note_ready}, 40'd1);

    // Single note: reset pulse, prep, go
    send_note(10'd200, 8'd127);
    check("a_v_reset", {36'd0, v_reset}, 40'h1);
    check("a_v_go_early", {36'd0, v_go}, 40'h0);
    check("a_v_delay0", {30'd0, v_delay[9:0]}, 40'd200);
    check("a_v_vel0", {32'd0, v_velocity[7:0]}, 40'd127);
    tick();
    check("a_v_reset_drop", {36'd0, v_reset}, 40'h0);
    tick(); tick(); tick();
    v_prepped = 4'b0001;
    check("a_v_go_t5", {36'd0, v_go}, 40'h0);
    tick();
    check("a_v_go_t6", {36'd0, v_go}, 40'h1);
    v_prepped = 4'b0000;
    tick();
    check("a_v_go_drop", {36'd0, v_go}, 40'h0);

    // Allocation order and stealing
    do_reset();
    for (int k = 0; k < 6; k++) begin
      send_note(10'(10 + k), 8'(k));
      check($sformatf("b_alloc%0d", k), {36'd0, v_reset}, {36'd0, steal_exp[k]});
    end
    check("b_steal_delay0", {30'd0, v_delay[9:0]}, 40'd14);
    check("b_steal_delay1", {30'd0, v_delay[19:10]}, 40'd15);

    // Prep timeout leaves voice 0 idle; idle search beats stealing rr
    do_reset();
    for (int k = 0; k < 5; k++) send_note(10'(20 + k), 8'd1);
    v_prepped = 4'b1110;
    go0 = 0;
    for (int n = 0; n < 8; n++) begin
      tick();
      if (v_go[0]) go0++;
    end
    check("e_prep_err_before", {36'd0, prep_err}, 40'h0);
    tick();
    check("e_prep_err_set", {36'd0, prep_err}, 40'h1);
    check("e_no_go0", 40'(go0), 40'd0);
    send_note(10'd30, 8'd2);
    check("e_idle_pick", {36'd0, v_reset}, 40'h1);
    check("e_prep_err_sticky", {36'd0, prep_err}, 40'h1);
    send_note(10'd31, 8'd3);
    check("e_steal_rr1", {36'd0, v_reset}, 40'h2);
    v_prepped = 4'b0000;

    // Mixer: saturation, signed sums, life expiry
    do_reset();
    send_note(10'd100, 8'd1);
    send_note(10'd101, 8'd2);
    v_prepped = 4'b0011;
    tick(); tick(); tick();
    v_prepped = 4'b0000;
    ready_en = 4'b0011;
    sample_full = 1'b0;
    for (int k = 0; k < 7; k++) begin
      v_data = {36'd0, d1[k], d0[k]};
      wait_sample();
      check($sformatf("c_sample%0d", k), {22'd0, sample_out}, {22'd0, sx[k]});
      check($sformatf("c_recv%0d", k), {36'd0, v_received}, (k < 6) ? 40'h3 : 40'h0);
      tick();
      check($sformatf("c_pulse%0d", k), {39'd0, sample_valid}, 40'd0);
    end

    // Back-pressure holds the mixer in its wait state
    sample_full = 1'b1;
    bad = 0;
    for (int n = 0; n < 100; n++) begin
      tick();
      if (sample_valid || (v_received != 4'b0000)) bad++;
    end
    check("d_full_quiet", 40'(bad), 40'd0);
    check("d_full_ready", {39'd0, note_ready}, 40'd1);
    sample_full = 1'b0;
    wait_sample();
    check("d_after_full", {22'd0, sample_out}, 40'd0);

    // Reset while the mixer is stuck in release
    do_reset();
    sample_full = 1'b1;
    send_note(10'd50, 8'd9);
    v_prepped = 4'b0001;
    tick(); tick(); tick();
    v_prepped = 4'b0000;
    v_data = {54'd0, 18'h00777};
    ready_en = 4'b0001;
    ready_hold = 4'b0001;
    sample_full = 1'b0;
    wait_sample();
    check("f_sample", {22'd0, sample_out}, 40'h777);
    check("f_recv", {36'd0, v_received}, 40'h1);
    tick(); tick();
    check("f_recv_held", {36'd0, v_received}, 40'h1);
    check("f_not_ready", {39'd0, note_ready}, 40'd0);
    reset = 1'b1;
    sample_full = 1'b1;
    ready_en = 4'b0000;
    ready_hold = 4'b0000;
    tick();
    check("f_recv_cleared", {36'd0, v_received}, 40'h0);
    check("f_voices_idle", {32'd0, v_reset, v_go}, 40'h0);
    reset = 1'b0;
    tick();
    check("f_ready_after", {39'd0, note_ready}, 40'd1);
    send_note(10'd60, 8'd3);
    check("f_alloc_v0", {36'd0, v_reset}, 40'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/voice_scheduler.md
VOICE_SCHEDULER -- requirements
Module: voice_scheduler

Interface
REQ-001 The block SHALL have parameter LIFE_SAMPLES, default 16'd48000, meaning the number of mixed samples a voice stays ACTIVE after its go pulse.
REQ-002 The block SHALL have parameter PREP_TIMEOUT, default 12'd4095, meaning the maximum number of cycles a voice waits for v_prepped.
REQ-003 The block SHALL have one clock; reset is synchronous and active-high, with ports as follows.
REQ-004 clk  in  1  system clock; all state changes on its rising edge.
REQ-005 reset  in  1  synchronous active-high reset.
REQ-006 note_valid  in  1  note-on request.
REQ-007 note_ready  out  1  scheduler can accept a note-on.
REQ-008 note_delay  in  10  string length for the note.
REQ-009 note_velocity  in  8  note amplitude.
REQ-010 v_reset, v_go  out  4 each  per-voice one-cycle reset and start pulses.
REQ-011 v_prepped  in  4  per-voice "buffer loaded" flag.
REQ-012 v_delay  out  40  per-voice delay; voice i uses bits [10i+9:10i].
REQ-013 v_velocity  out  32  per-voice velocity; voice i uses bits [8i+7:8i].
REQ-014 v_ready  in  4  per-voice "sample available" flag.
REQ-015 v_received  out  4  per-voice sample acknowledge.
REQ-016 v_data  in  72  per-voice signed sample; voice i uses bits [18i+17:18i].
REQ-017 sample_out  out  18  mixed signed sample.
REQ-018 sample_valid  out  1  one-cycle strobe for sample_out.
REQ-019 sample_full  in  1  downstream FIFO full.
REQ-020 prep_err  out  4  sticky per-voice prep-timeout flag.

Function
REQ-021 Each voice SHALL run the FSM IDLE -> RST (1 cycle, v_reset[i]=1) -> PREP -> GO (1 cycle, v_go[i]=1) -> ACTIVE -> IDLE.
REQ-022 A note SHALL be accepted on a cycle where note_valid and note_ready are both 1; note_ready SHALL be 1 only when the mixer FSM is in M_WAIT.
REQ-023 On acceptance, the target voice SHALL be the first IDLE voice found searching upward from the round-robin pointer rr (mod 4); if no voice is IDLE, the target SHALL be voice rr (steal).
REQ-024 On acceptance, rr SHALL become (target+1) mod 4, note_delay and note_velocity SHALL be latched into the target's v_delay and v_velocity fields, and the target SHALL enter RST on the next cycle regardless of its prior state.
REQ-025 In PREP, v_prepped[i]=1 SHALL move the voice to GO; if PREP_TIMEOUT cycles elapse first, the voice SHALL go to IDLE and set prep_err[i].
REQ-026 In ACTIVE, the voice SHALL count mixed samples and return to IDLE after LIFE_SAMPLES samples.
REQ-027 The mixer FSM SHALL have states M_WAIT, M_ACK, M_REL.
REQ-028 In M_WAIT, when sample_full=0 and every ACTIVE voice has v_ready=1, the mixer SHALL latch the set of ACTIVE voices as S and go to M_ACK.
REQ-029 In M_ACK (1 cycle), the mixer SHALL capture v_data for the voices in S, assert v_received for S, and go to M_REL.
REQ-030 In M_REL, v_received for S SHALL stay high until every voice in S shows v_ready=0; v_received SHALL then drop and the mixer SHALL return to M_WAIT.
REQ-031 Sum SHALL be the signed 20-bit total of the captured samples, with 0 for voices not in S, saturated to the range [-131072, 131071].
REQ-032 sample_out SHALL update and sample_valid SHALL pulse one cycle on the cycle after M_ACK.
REQ-033 With no ACTIVE voices, the mixer SHALL still cycle (S empty) and emit sample_out=0 whenever sample_full=0.
REQ-034 A voice leaving ACTIVE (stolen, or life expired) while in S SHALL still complete the current M_REL release.
REQ-035 While sample_full=1, the mixer SHALL not leave M_WAIT and no v_received SHALL be asserted.

Reset
REQ-036 When reset=1, all voices SHALL be IDLE, the mixer SHALL be in M_WAIT, rr SHALL be 0, life and timeout counters SHALL be 0, and all outputs including prep_err SHALL be 0.
REQ-037 note_ready SHALL be 1 from the first cycle after reset is released.
REQ-038 A reset asserted mid-operation SHALL abort any handshake immediately, with v_received at 0 on the next cycle.

Verification
REQ-039 Scenario: note (delay 200, velocity 127) after reset -> v_reset[0] pulses at T+1; v_prepped[0] raised at T+5 -> v_go[0] pulses at T+6; v_delay[9:0]=200.
REQ-040 Scenario: five notes with all voices busy -> voices 0,1,2,3 allocated, then voice 0 stolen; rr=1 afterwards.
REQ-041 Scenario: two ACTIVE voices supplying 18'h1FFFF each -> sample_out=18'h1FFFF (saturated positive); two supplying 18'h20000 -> 18'h20000.
REQ-042 Scenario: sample_full held high for 100 cycles -> no sample_valid and v_received=0 throughout; first sample appears after sample_full falls.
REQ-043 Scenario: v_prepped never asserted -> after PREP_TIMEOUT cycles voice 0 returns to IDLE and prep_err[0]=1.
REQ-044 Scenario: reset asserted during M_REL -> v_received=0 and all voices IDLE on the next cycle; note_ready=1 after reset is released.
